serial_cmp_ctrl: RTL and testbench
==================================

# serial_cmp_ctrl

- Sequencing controller that compares two WIDTH-bit unsigned operands two bits per cycle, MSB-first.
- Reuses a single 2-bit magnitude-compare slice instead of a full-width comparator.
- Sits in front of area-constrained datapaths needing occasional wide compares.
- Accepts a start pulse, steps the slice over operand pairs, and reports one-hot gt/eq/lt with a single-cycle done strobe.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; must be even and ≥2; K = WIDTH/2 slice steps.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- busy  output  1  high in RUN and DONE states.
- done  output  1  one-cycle strobe when the result becomes valid.
- gt  output  1  A > B.
- eq  output  1  A == B.
- lt  output  1  A < B.

## Operation
- Reset value of every output is 0 (busy, done, gt, eq, lt); state returns to IDLE.
- State machine:
  - IDLE: on start=1, load a/b into shift registers, set step counter to K, clear gt/eq/lt, go to RUN.
  - RUN: each cycle, compare the top 2 bits of both shift registers through the slice, then shift both left by 2 and decrement the counter.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Decision register: the first unequal pair sets gt or lt, and that value is sticky. If all K pairs are equal, eq=1.
- Leaving RUN: exit after the K-th step, or earlier on the first unequal pair (see Configuration).
- gt/eq/lt update on entry to DONE and hold through IDLE until the next accepted start.
- After any completed compare, exactly one of gt/eq/lt is high.
- start while busy=1 (RUN or DONE) is ignored; the operands are not recaptured.
- a/b changing after capture has no effect.
- rst=1 mid-operation: abort; next cycle is IDLE with all outputs 0. A result in progress is discarded.
- WIDTH=2: a single RUN cycle.

## Timing
- Cycle 0: start accepted in IDLE.
- Cycles 1..K: RUN.
- Constant-time mode: done=1 in cycle K+1, and busy is high for cycles 1..K+1.
- Early-exit mode: first unequal pair at step j (1-based from MSB), then done=1 in cycle j+1.
- Earliest next accepted start is the cycle after done (IDLE).
- Latency counted from the cycle start is sampled to the done cycle.

## Configuration
- SERIAL_CMP_EARLY_EXIT_EN
  - Defined: RUN terminates on the first unequal pair, so latency is data-dependent (2..K+1 cycles).
  - Undefined: RUN always runs all K steps, so latency is constant at K+1 cycles. This is the constant-time mode.
- Result values are identical in both modes.

## Structure
- Shared package cmp_pkg holds:
  - state typedef {IDLE, RUN, DONE};
  - localparam-style constants for the result encoding (GT, EQ, LT one-hot);
  - a width-check constant (WIDTH%2==0).
- Sub-module cmp2_slice: purely combinational. Inputs are 2-bit x and y; outputs are one-hot gt/eq/lt. It is instantiated once.
- The controller holds the FSM, shift registers, counter and decision register.

## Test plan
All scenarios use WIDTH=8.
- a=8'hA5, b=8'hA5, start at cycle 0 -> done at cycle 5 with eq=1, gt=lt=0, in both modes.
- a=8'h80, b=8'h7F -> gt=1; done at cycle 2 with _EN defined, at cycle 5 without.
- a=8'h12, b=8'h13 -> lt=1; done at cycle 5 in both modes (difference is in the last pair).
- start re-pulsed at cycles 2 and 3 with new operands -> ignored; the result reflects the first operands; exactly one done.
- rst asserted at cycle 3 of a compare -> cycle 4 has busy=done=gt=eq=lt=0; a new start then completes normally.
- Back-to-back: start in the cycle after done -> accepted; gt/eq/lt clear on acceptance and the second result is correct.

Source files
------------

// File: rtl/serial_cmp_ctrl_pkg.sv
// Shared types and constants for the serial magnitude comparator.
//   state_t    : controller states IDLE / RUN / DONE
//   res_t      : one-hot result {gt, eq, lt}
//   width_ok() : operand width must be even and at least 2
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef logic [2:0] res_t;

  localparam res_t RES_GT   = 3'b100;
  localparam res_t RES_EQ   = 3'b010;
  localparam res_t RES_LT   = 3'b001;
  localparam res_t RES_NONE = 3'b000;

  function automatic bit width_ok(input int unsigned w);
    return ((w % 2) == 0) && (w >= 2);
  endfunction

endpackage

// File: rtl/serial_cmp_ctrl_if.sv
// Request/result bundle for serial_cmp_ctrl.
//   start, a, b            : request side (driven by master)
//   busy, done, gt, eq, lt : status and result (driven by slave)
interface serial_cmp_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output start, a, b,
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  start, a, b,
    output busy, done, gt, eq, lt
  );

endinterface

// File: rtl/serial_cmp_ctrl_cmp2_slice.sv
// Combinational 2-bit unsigned magnitude compare.
//   x, y         : 2-bit operands
//   gt / eq / lt : one-hot result of x vs y
module cmp2_slice (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  assign gt = (x > y);
  assign eq = (x == y);
  assign lt = (x < y);

endmodule

// File: rtl/serial_cmp_ctrl.sv
// Serial WIDTH-bit unsigned comparator, two bits per cycle, MSB first,
// built around one shared cmp2_slice.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   bus      : slave side of serial_cmp_ctrl_if
//              start (sampled in IDLE), a/b (captured on accepted start),
//              busy (RUN or DONE), done (one-cycle strobe), gt/eq/lt (held)
// Build option: define SERIAL_CMP_EARLY_EXIT_EN to leave RUN on the first
// unequal pair; otherwise every compare takes all WIDTH/2 steps.
module serial_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_cmp_ctrl_if.slave bus
);

  localparam int unsigned K  = WIDTH / 2;
  localparam int unsigned CW = $clog2(K + 1);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("serial_cmp_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic             decided;
  logic             dec_gt;
  res_t             res;
  res_t             res_nxt;
  logic             s_gt;
  logic             s_eq;
  logic             s_lt;
  logic             last_step;

  cmp2_slice u_slice (
    .x  (sh_a[WIDTH-1 -: 2]),
    .y  (sh_b[WIDTH-1 -: 2]),
    .gt (s_gt),
    .eq (s_eq),
    .lt (s_lt)
  );

  // A pair already decided stays sticky; otherwise the current slice decides.
  always_comb begin
    res_nxt   = RES_EQ;
    last_step = (cnt == CW'(1)) || (EARLY_EXIT && !s_eq);
    if (decided) begin
      res_nxt = dec_gt ? RES_GT : RES_LT;
    end else if (s_gt) begin
      res_nxt = RES_GT;
    end else if (s_lt) begin
      res_nxt = RES_LT;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a    <= '0;
      sh_b    <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      dec_gt  <= 1'b0;
      res     <= RES_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh_a    <= bus.a;
            sh_b    <= bus.b;
            cnt     <= CW'(K);
            decided <= 1'b0;
            dec_gt  <= 1'b0;
            res     <= RES_NONE;
          end
        end
        RUN: begin
          sh_a <= sh_a << 2;
          sh_b <= sh_b << 2;
          cnt  <= cnt - CW'(1);
          if (!decided && !s_eq) begin
            decided <= 1'b1;
            dec_gt  <= s_gt;
          end
          // Result becomes visible only on entry to DONE.
          if (last_step) begin
            res <= res_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.gt   = res[2];
  assign bus.eq   = res[1];
  assign bus.lt   = res[0];

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Scoreboard bench for serial_cmp_ctrl (WIDTH = 8). Expected results and
// done timing are computed from operand values when a start is issued; a
// monitor compares every cycle against the head of the queue.
module tb_serial_cmp_ctrl;

  localparam int unsigned W = 8;
  localparam int unsigned K = W / 2;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [2:0]  res;
    int unsigned start_edge;
    int unsigned done_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  serial_cmp_ctrl_if #(.WIDTH(W)) bus ();

  serial_cmp_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain magnitude compare, plus the 1-based index of the first
  // differing 2-bit group from the MSB to derive latency.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int unsigned s);
    exp_t        e;
    int unsigned j = 0;
    int unsigned lat;
    logic [1:0]  pa;
    logic [1:0]  pb;
    if (a > b)       e.res = 3'b100;
    else if (a == b) e.res = 3'b010;
    else             e.res = 3'b001;
    for (int unsigned i = 1; i <= K; i++) begin
      pa = 2'((a >> (W - 2 * i)) & 3);
      pb = 2'((b >> (W - 2 * i)) & 3);
      if (pa != pb && j == 0) j = i;
    end
    lat = (EARLY && j != 0) ? j + 1 : K + 1;
    e.start_edge = s;
    e.done_edge  = s + lat - 1;
    return e;
  endfunction

  // Monitor: done must appear exactly on the predicted edge with the
  // predicted result; between acceptance and done, busy is high and the
  // result register is cleared.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst) begin
        if (sbq.size() != 0 && cyc == sbq[0].done_edge) begin
          chk("done_strobe", 32'(bus.done), 32'd1);
          chk("busy_at_done", 32'(bus.busy), 32'd1);
          chk("result", 32'({bus.gt, bus.eq, bus.lt}), 32'(sbq[0].res));
          void'(sbq.pop_front());
        end else begin
          chk("no_spurious_done", 32'(bus.done), 32'd0);
          if (sbq.size() != 0 && cyc > sbq[0].start_edge) begin
            chk("busy_in_run", 32'(bus.busy), 32'd1);
            chk("result_cleared_in_run", 32'({bus.gt, bus.eq, bus.lt}), 32'd0);
          end
        end
      end
    end
  end

  // Called at a negedge with the DUT idle; start is sampled at the next edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    sbq.push_back(model(a, b, cyc + 1));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
  endtask

  // Wait for the DUT to return to IDLE; optionally pulse ignored starts with
  // fresh operands while it is busy.
  task automatic wait_idle(input bit junk);
    int n = 0;
    while (!(sbq.size() == 0 && !bus.busy)) begin
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout: busy=%0b pending=%0d expected idle", bus.busy, sbq.size());
        sbq.delete();
        break;
      end
      n++;
      if (junk) begin
        bus.start = ($urandom % 3 == 0);
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           n;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({bus.busy, bus.done, bus.gt, bus.eq, bus.lt}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Equal operands, first-pair difference, last-pair difference.
    issue(8'hA5, 8'hA5);
    wait_idle(1'b0);
    issue(8'h80, 8'h7F);
    wait_idle(1'b1);
    issue(8'h12, 8'h13);
    wait_idle(1'b1);

    // Result holds through IDLE.
    repeat (3) @(negedge clk);
    chk("result_held_idle", 32'({bus.gt, bus.eq, bus.lt}), 32'b001);

    // Start re-pulsed in cycles 2 and 3 with different operands.
    issue(8'h3C, 8'h3C);
    bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'h00;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h00; bus.b = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(1'b0);

    // Reset sampled at the end of cycle 3 of a compare.
    issue(8'h5A, 8'h5B);
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    @(posedge clk);
    #2;
    chk("abort_outputs", 32'({bus.busy, bus.done, bus.gt, bus.eq, bus.lt}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(8'hC3, 8'hC2);
    wait_idle(1'b1);

    // Back-to-back: start in the cycle right after done.
    issue(8'hF0, 8'h0F);
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    issue(8'h0F, 8'hF0);
    wait_idle(1'b0);

    // Randomized compares, biased toward shared upper groups.
    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom);
      case ($urandom % 3)
        0:       rb = W'($urandom);
        1:       rb = ra;
        default: rb = ra ^ W'($urandom_range(1, 3) << (2 * $urandom_range(0, K - 1)));
      endcase
      issue(ra, rb);
      wait_idle($urandom % 2 == 0);
      repeat ($urandom % 3) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
